// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that lets N_REQ requesters write bursts of up to
//   BURST_LEN words into a single dual-clock FIFO (write side only).
//   A grant is issued only when the FIFO has room for a whole burst; every
//   burst is followed by one idle GAP cycle so fifo_wrusedw can settle
//   before the next space check.
//
// Ports
//   wrclk         write-side clock, all logic on rising edge
//   rst_n         asynchronous active-low reset
//   req           per-requester level request
//   req_data      packed lanes, lane i = req_data[i*DW +: DW]
//   ack           per-requester word-consumed strobe
//   grant         one-hot current owner, or zero
//   fifo_data     FIFO data port
//   fifo_wrreq    FIFO write request
//   fifo_wrusedw  FIFO write-side fill level
//   fifo_wrfull   FIFO write-side full flag
//   busy          high whenever the FSM is not idle
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DW        = 8,
   parameter int AW        = 5,
   parameter int BURST_LEN = 4
) (
   input  logic                wrclk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    ack,
   output logic [N_REQ-1:0]    grant,
   output logic [DW-1:0]       fifo_data,
   output logic                fifo_wrreq,
   input  logic [AW-1:0]       fifo_wrusedw,
   input  logic                fifo_wrfull,
   output logic                busy
);

   localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

   state_t                     state;
   logic [N_REQ-1:0]           grant_q;
   logic [LW-1:0]              last;
   logic [LW-1:0]              win;
   logic [LW-1:0]              idx;
   logic                       win_vld;
   logic [AW:0]                beat;
   logic [AW:0]                free;
   logic [DW-1:0]              data_q;
   logic [DW-1:0]              lane_sel;
   logic [N_REQ-1:0][DW-1:0]   lanes;
   logic                       own_req;
   logic                       wr;

   genvar g;
   generate
      for (g = 0; g < N_REQ; g++) begin : g_lane
         assign lanes[g] = req_data[g*DW +: DW];
      end
   endgenerate

   // grant_q is one-hot or zero, so OR-ing the selected lanes is a mux
   always_comb begin
      lane_sel = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant_q[i]) lane_sel = lane_sel | lanes[i];
   end

   // full flag overrides the level: a full FIFO may report wrusedw=0
   always_comb begin
      free = '0;
      if (!fifo_wrfull)
         free = {1'b1, {AW{1'b0}}} - {1'b0, fifo_wrusedw};
   end

   // round-robin search starting just after the previous winner
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = LW'((int'(last) + k) % N_REQ);
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   assign own_req    = |(req & grant_q);
   assign wr         = (state == BURST) && own_req && !fifo_wrfull;
   assign fifo_wrreq = wr;
   assign ack        = wr ? grant_q : '0;
   assign grant      = grant_q;
   // between writes the port shows the last word written
   assign fifo_data  = wr ? lane_sel : data_q;
   assign busy       = (state != IDLE);

   always_ff @(posedge wrclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         grant_q <= '0;
         beat    <= '0;
         last    <= LW'(N_REQ - 1);
         data_q  <= '0;
      end else begin
         if (wr) data_q <= lane_sel;
         case (state)
            IDLE: begin
               if (win_vld && free >= (AW+1)'(BURST_LEN)) begin
                  grant_q      <= '0;
                  grant_q[win] <= 1'b1;
                  last         <= win;
                  beat         <= '0;
                  state        <= BURST;
               end
            end
            BURST: begin
               // a dropped request ends the burst even while stalled on full
               if (!own_req) begin
                  grant_q <= '0;
                  beat    <= '0;
                  state   <= GAP;
               end else if (!fifo_wrfull) begin
                  if (beat == (AW+1)'(BURST_LEN - 1)) begin
                     grant_q <= '0;
                     beat    <= '0;
                     state   <= GAP;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
